proc_sequencer: RTL

Program sequencer for the 9-bit `proc` datapath. It fetches instruction words and `mvi` immediates from a synchronous-read program memory and drives them onto the processor's `DIN`. It then pulses `Run`, waits for `Done`, and advances the program counter, replacing the manual switch/Run operation used on the board. It also stops the program on a HALT opcode and enters a fault state if `Done` never arrives.

---
 rtl/proc_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// Program sequencer for the 9-bit proc datapath: fetches instructions and mvi
// immediates from a synchronous-read memory, pulses Run, waits for Done.
module proc_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              halted,
  output logic              fault,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_F_INSTR, S_W_INSTR, S_F_IMM, S_W_IMM, S_ISSUE, S_EXEC, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int         WD_W    = $clog2(TIMEOUT);
  // Last wdog value still waited on; the next Done-less edge faults.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_cnt;
  logic [8:0]        r_instr, r_imm, r_din;
  logic [WD_W-1:0]   r_wdog;
  logic              w_start_prog, w_nop_adv, w_retire, w_wdog_inc;
  logic              w_is_mvi, w_rd_nop;
  logic [2:0]        w_rd_op;

  assign w_rd_op  = mem_rdata[2:0];
  assign w_rd_nop = w_rd_op[2] && (w_rd_op != OP_HALT);
  assign w_is_mvi = (r_instr[2:0] == OP_MVI);

  always_comb begin
    w_state_nxt  = r_state;
    w_start_prog = 1'b0;
    w_nop_adv    = 1'b0;
    w_retire     = 1'b0;
    w_wdog_inc   = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = r_pc;
    Run          = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (r_state)
      S_IDLE, S_HALT, S_FAULT: begin
        halted = (r_state == S_HALT);
        fault  = (r_state == S_FAULT);
        if (Start) begin
          w_state_nxt  = S_F_INSTR;
          w_start_prog = 1'b1;
        end
      end
      S_F_INSTR: begin
        mem_en      = 1'b1;
        w_state_nxt = S_W_INSTR;
      end
      S_W_INSTR: begin
        if (w_rd_op == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else if (w_rd_nop) begin
          w_state_nxt = S_F_INSTR;
          w_nop_adv   = 1'b1;
        end else if (w_rd_op == OP_MVI) begin
          w_state_nxt = S_F_IMM;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_F_IMM: begin
        mem_en      = 1'b1;
        mem_addr    = r_pc + ADDR_W'(1);
        w_state_nxt = S_W_IMM;
      end
      S_W_IMM: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        Run         = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (Done) begin
          w_retire    = 1'b1;
          w_state_nxt = S_F_INSTR;
        end else if (r_wdog == WD_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wdog_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_imm   <= '0;
      r_din   <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_prog) begin
        r_pc  <= '0;
        r_cnt <= '0;
      end
      if (w_nop_adv) r_pc <= r_pc + ADDR_W'(1);
      if (w_retire) begin
        r_pc <= r_pc + (w_is_mvi ? ADDR_W'(2) : ADDR_W'(1));
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == S_W_INSTR) r_instr <= mem_rdata;
      if (r_state == S_W_IMM)   r_imm   <= mem_rdata;
      // DIN is registered one edge ahead so it never depends on Done or mem_rdata.
      if (r_state == S_W_INSTR && w_state_nxt == S_ISSUE) r_din <= mem_rdata;
      if (r_state == S_W_IMM) r_din <= r_instr;
      if (r_state == S_ISSUE) r_din <= w_is_mvi ? r_imm : r_instr;
      if (r_state == S_ISSUE)  r_wdog <= '0;
      else if (w_wdog_inc)     r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign DIN         = r_din;
  assign pc          = r_pc;
  assign instr_count = r_cnt;
  assign dbg_state   = r_state;

endmodule
